// File: rtl/scratch_pad_arbiter.sv
// Round-robin arbiter sharing one single-port scratch-pad SRAM among NumReq requesters.
// Registered SRAM command in stage 1, read response returned in stage 2 (fixed 2-cycle latency).
module scratch_pad_arbiter #(
  parameter int  DWidth = 8,
  parameter int  Depth  = 1024,
  parameter int  NumReq = 2,
  localparam int Index  = $clog2(Depth),
  localparam int PtrW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq-1:0]        req_we_i,
  input  logic [NumReq*Index-1:0]  req_addr_i,
  input  logic [NumReq*DWidth-1:0] req_wdata_i,
  output logic [NumReq-1:0]        rsp_valid_o,
  output logic                     rsp_err_o,
  output logic [DWidth-1:0]        rsp_rdata_o,
  output logic                     sram_csb_o,
  output logic                     sram_web_o,
  output logic                     sram_oeb_o,
  output logic [Index-1:0]         sram_addr_o,
  output logic [DWidth-1:0]        sram_wdata_o,
  input  logic [DWidth-1:0]        sram_rdata_i
);

  function automatic logic [NumReq-1:0] id_to_onehot(input logic [PtrW-1:0] id);
    logic [NumReq-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  logic [PtrW-1:0]   ptr_r;
  logic [PtrW-1:0]   win_s;
  logic [PtrW-1:0]   ptr_nxt_s;
  logic [PtrW:0]     scan_s;
  logic [NumReq-1:0] grant_s;
  logic              found_s;
  logic              sel_we_s;
  logic              in_range_s;
  logic [Index-1:0]  sel_addr_s;
  logic [DWidth-1:0] sel_wdata_s;

  logic              csb_r;
  logic              web_r;
  logic [Index-1:0]  addr_r;
  logic [DWidth-1:0] wdata_r;
  logic              s1_rd_r;
  logic              s1_err_r;
  logic [PtrW-1:0]   s1_id_r;

  logic              oeb_r;
  logic [NumReq-1:0] rsp_valid_r;
  logic              rsp_err_r;

  // Round-robin scan starting at ptr_r; first valid requester wins.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    win_s   = '0;
    scan_s  = '0;
    for (int k = 0; k < NumReq; k++) begin
      scan_s = {1'b0, ptr_r} + (PtrW+1)'(k);
      if (scan_s >= (PtrW+1)'(NumReq)) begin
        scan_s = scan_s - (PtrW+1)'(NumReq);
      end else begin
        scan_s = scan_s;
      end
      if (!found_s && req_valid_i[scan_s[PtrW-1:0]]) begin
        grant_s[scan_s[PtrW-1:0]] = 1'b1;
        win_s                     = scan_s[PtrW-1:0];
        found_s                   = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Winner's command fields, address range check and next pointer.
  always_comb begin
    sel_we_s    = req_we_i[win_s];
    sel_addr_s  = req_addr_i[win_s*Index +: Index];
    sel_wdata_s = req_wdata_i[win_s*DWidth +: DWidth];
    in_range_s  = (32'(sel_addr_s) < 32'(Depth));
    if (win_s == PtrW'(NumReq-1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_s + PtrW'(1);
    end
  end

  // Pointer advances past the winner only when a handshake happens.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // Stage 1: SRAM command register; out-of-range commands never select the macro.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csb_r    <= 1'b1;
      web_r    <= 1'b1;
      addr_r   <= '0;
      wdata_r  <= '0;
      s1_rd_r  <= 1'b0;
      s1_err_r <= 1'b0;
      s1_id_r  <= '0;
    end else begin
      csb_r    <= ~(found_s & in_range_s);
      web_r    <= ~(found_s & in_range_s & sel_we_s);
      if (found_s && in_range_s) begin
        addr_r  <= sel_addr_s;
        wdata_r <= sel_wdata_s;
      end
      s1_rd_r  <= found_s & ~sel_we_s;
      s1_err_r <= ~in_range_s;
      s1_id_r  <= win_s;
    end
  end

  // Stage 2: read response qualifiers and SRAM output enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      oeb_r       <= 1'b1;
      rsp_valid_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      oeb_r       <= ~(s1_rd_r & ~s1_err_r);
      rsp_valid_r <= s1_rd_r ? id_to_onehot(s1_id_r) : '0;
      rsp_err_r   <= s1_rd_r & s1_err_r;
    end
  end

  assign req_ready_o  = grant_s;
  assign sram_csb_o   = csb_r;
  assign sram_web_o   = web_r;
  assign sram_oeb_o   = oeb_r;
  assign sram_addr_o  = addr_r;
  assign sram_wdata_o = wdata_r;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_err_o    = rsp_err_r;
  // SRAM data arrives during stage 2, so it is gated rather than registered again.
  assign rsp_rdata_o  = ((|rsp_valid_r) && !rsp_err_r) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_scratch_pad_arbiter.sv
// Directed bench: main instance (Depth 1024) with a behavioural SRAM, plus a Depth 1000
// instance sharing the request inputs for out-of-range checks.
module tb_scratch_pad_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  valid = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [9:0]  a0 = 10'h000, a1 = 10'h000;
  logic [7:0]  d0 = 8'h00, d1 = 8'h00;

  logic [1:0]  rdy_a, rv_a, rdy_b, rv_b;
  logic        err_a, err_b, csb_a, web_a, oeb_a, csb_b, web_b, oeb_b;
  logic [7:0]  rd_a, rd_b, wd_a, wd_b, sram_rdata;
  logic [9:0]  addr_a, addr_b;
  logic [7:0]  mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  scratch_pad_arbiter #(.DWidth(8), .Depth(1024), .NumReq(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy_a), .req_we_i(we),
    .req_addr_i({a1, a0}), .req_wdata_i({d1, d0}), .rsp_valid_o(rv_a), .rsp_err_o(err_a),
    .rsp_rdata_o(rd_a), .sram_csb_o(csb_a), .sram_web_o(web_a), .sram_oeb_o(oeb_a),
    .sram_addr_o(addr_a), .sram_wdata_o(wd_a), .sram_rdata_i(sram_rdata));

  scratch_pad_arbiter #(.DWidth(8), .Depth(1000), .NumReq(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(rdy_b), .req_we_i(we),
    .req_addr_i({a1, a0}), .req_wdata_i({d1, d0}), .rsp_valid_o(rv_b), .rsp_err_o(err_b),
    .rsp_rdata_o(rd_b), .sram_csb_o(csb_b), .sram_web_o(web_b), .sram_oeb_o(oeb_b),
    .sram_addr_o(addr_b), .sram_wdata_o(wd_b), .sram_rdata_i(8'hFF));

  // Behavioural single-port SRAM: command sampled at the edge, read data after it.
  always @(posedge clk) begin
    if (!csb_a) begin
      if (!web_a) mem[addr_a] <= wd_a;
      else        sram_rdata  <= mem[addr_a];
    end
  end

  typedef struct {
    bit         rst_before;
    logic [1:0] v, w;
    logic [9:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] rdy;
    logic       csb, web, oeb;
    logic [9:0] addr;
    logic [1:0] rv;
    logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(bit rb, logic [1:0] v, logic [1:0] w, logic [9:0] x0, logic [9:0] x1,
                              logic [7:0] y0, logic [7:0] y1, logic [1:0] rdy, logic csb, logic web,
                              logic oeb, logic [9:0] addr, logic [1:0] rv, logic [7:0] rd);
    vec_t t;
    t.rst_before = rb; t.v = v; t.w = w; t.a0 = x0; t.a1 = x1; t.d0 = y0; t.d1 = y1;
    t.rdy = rdy; t.csb = csb; t.web = web; t.oeb = oeb; t.addr = addr; t.rv = rv; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid = 2'b00; we = 2'b00; a0 = 10'h000; a1 = 10'h000; d0 = 8'h00; d1 = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [9:0] x0,
                       input logic [9:0] x1, input logic [7:0] y0, input logic [7:0] y1);
    @(posedge clk);
    #1;
    valid = v; we = w; a0 = x0; a1 = x1; d0 = y0; d1 = y1;
    @(negedge clk);
  endtask

  vec_t tbl [27];

  initial begin
    // Test 1: req0 writes A5@010 (req1 writes 5A@020 alongside), then req0 reads 010
    tbl[0]  = mk(0, 2'b11, 2'b11, 10'h010, 10'h020, 8'hA5, 8'h5A, 2'b01, 1, 1, 1, 10'h000, 2'b00, 8'h00);
    tbl[1]  = mk(0, 2'b10, 2'b11, 10'h010, 10'h020, 8'hA5, 8'h5A, 2'b10, 0, 0, 1, 10'h010, 2'b00, 8'h00);
    tbl[2]  = mk(0, 2'b01, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b01, 0, 0, 1, 10'h020, 2'b00, 8'h00);
    tbl[3]  = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 0, 1, 1, 10'h010, 2'b00, 8'h00);
    tbl[4]  = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1, 1, 0, 10'h000, 2'b01, 8'hA5);
    tbl[5]  = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1, 1, 1, 10'h000, 2'b00, 8'h00);
    // Test 2: both reading continuously after reset -> 0,1,0,1,0,1
    tbl[6]  = mk(1, 2'b11, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b01, 1, 1, 1, 10'h000, 2'b00, 8'h00);
    tbl[7]  = mk(0, 2'b11, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b10, 0, 1, 1, 10'h010, 2'b00, 8'h00);
    tbl[8]  = mk(0, 2'b11, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b01, 0, 1, 0, 10'h020, 2'b01, 8'hA5);
    tbl[9]  = mk(0, 2'b11, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b10, 0, 1, 0, 10'h010, 2'b10, 8'h5A);
    tbl[10] = mk(0, 2'b11, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b01, 0, 1, 0, 10'h020, 2'b01, 8'hA5);
    tbl[11] = mk(0, 2'b11, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b10, 0, 1, 0, 10'h010, 2'b10, 8'h5A);
    tbl[12] = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 0, 1, 0, 10'h020, 2'b01, 8'hA5);
    tbl[13] = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1, 1, 0, 10'h000, 2'b10, 8'h5A);
    tbl[14] = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1, 1, 1, 10'h000, 2'b00, 8'h00);
    // Test 3: only req1 for 3 cycles, then both -> req0 wins next
    tbl[15] = mk(0, 2'b10, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b10, 1, 1, 1, 10'h000, 2'b00, 8'h00);
    tbl[16] = mk(0, 2'b10, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b10, 0, 1, 1, 10'h020, 2'b00, 8'h00);
    tbl[17] = mk(0, 2'b10, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b10, 0, 1, 0, 10'h020, 2'b10, 8'h5A);
    tbl[18] = mk(0, 2'b11, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00, 2'b01, 0, 1, 0, 10'h020, 2'b10, 8'h5A);
    tbl[19] = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 0, 1, 0, 10'h010, 2'b10, 8'h5A);
    tbl[20] = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1, 1, 0, 10'h000, 2'b01, 8'hA5);
    tbl[21] = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1, 1, 1, 10'h000, 2'b00, 8'h00);
    // Test 4: req1 writes 3C@3FF, req0 reads 3FF next cycle
    tbl[22] = mk(0, 2'b10, 2'b10, 10'h000, 10'h3FF, 8'h00, 8'h3C, 2'b10, 1, 1, 1, 10'h000, 2'b00, 8'h00);
    tbl[23] = mk(0, 2'b01, 2'b00, 10'h3FF, 10'h3FF, 8'h00, 8'h3C, 2'b01, 0, 0, 1, 10'h3FF, 2'b00, 8'h00);
    tbl[24] = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 0, 1, 1, 10'h3FF, 2'b00, 8'h00);
    tbl[25] = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1, 1, 0, 10'h000, 2'b01, 8'h3C);
    tbl[26] = mk(0, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1, 1, 1, 10'h000, 2'b00, 8'h00);

    // Reset values
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(rdy_a), 32'h0);
    chk("reset rsp_valid", 32'(rv_a), 32'h0);
    chk("reset rsp_err", 32'(err_a), 32'h0);
    chk("reset rdata", 32'(rd_a), 32'h0);
    chk("reset csb/web/oeb", 32'({csb_a, web_a, oeb_a}), 32'h7);
    chk("reset addr", 32'(addr_a), 32'h0);
    chk("reset wdata", 32'(wd_a), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      if (tbl[i].rst_before) do_reset();
      drive(tbl[i].v, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      chk($sformatf("row%0d ready", i), 32'(rdy_a), 32'(tbl[i].rdy));
      chk($sformatf("row%0d csb", i), 32'(csb_a), 32'(tbl[i].csb));
      chk($sformatf("row%0d web", i), 32'(web_a), 32'(tbl[i].web));
      chk($sformatf("row%0d oeb", i), 32'(oeb_a), 32'(tbl[i].oeb));
      if (tbl[i].csb == 1'b0) chk($sformatf("row%0d addr", i), 32'(addr_a), 32'(tbl[i].addr));
      chk($sformatf("row%0d rsp_valid", i), 32'(rv_a), 32'(tbl[i].rv));
      chk($sformatf("row%0d rsp_err", i), 32'(err_a), 32'h0);
      chk($sformatf("row%0d rdata", i), 32'(rd_a), 32'(tbl[i].rd));
    end

    // Test 5: Depth 1000 instance, read and write at 1010
    do_reset();
    drive(2'b01, 2'b00, 10'd1010, 10'd0, 8'h00, 8'h00);
    chk("oor rd ready", 32'(rdy_b), 32'h1);
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);
    chk("oor rd csb/web", 32'({csb_b, web_b}), 32'h3);
    drive(2'b01, 2'b01, 10'd1010, 10'd0, 8'h77, 8'h00);
    chk("oor rd rsp_valid", 32'(rv_b), 32'h1);
    chk("oor rd rsp_err", 32'(err_b), 32'h1);
    chk("oor rd rdata", 32'(rd_b), 32'h0);
    chk("oor rd oeb", 32'(oeb_b), 32'h1);
    chk("oor wr ready", 32'(rdy_b), 32'h1);
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);
    chk("oor wr csb/web", 32'({csb_b, web_b}), 32'h3);
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'h00, 8'h00);
    chk("oor wr rsp_valid", 32'(rv_b), 32'h0);
    chk("oor wr rsp_err", 32'(err_b), 32'h0);

    // Test 6: reset one cycle after a read handshake
    do_reset();
    drive(2'b01, 2'b00, 10'h010, 10'h000, 8'h00, 8'h00);
    drive(2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00);
    chk("pre-reset csb", 32'(csb_a), 32'h0);
    rst = 1'b1;
    #1;
    chk("mid reset csb/web/oeb", 32'({csb_a, web_a, oeb_a}), 32'h7);
    chk("mid reset addr/wdata", 32'({addr_a, wd_a}), 32'h0);
    chk("mid reset rsp", 32'({rv_a, err_a, rd_a}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post reset rsp_valid c%0d", c), 32'(rv_a), 32'h0);
    end
    drive(2'b11, 2'b00, 10'h010, 10'h020, 8'h00, 8'h00);
    chk("post reset pointer", 32'(rdy_a), 32'h1);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
